lap_timer_core: RTL and testbench
=================================

LAP_TIMER_CORE -- requirements
Module: lap_timer_core

Interface
REQ-001 The block SHALL have parameter MIN_LIMIT, default 59, meaning the maximum minutes value (legal range 1..99).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port tick  input  1  one-cycle count-rate pulse (1 Hz in system use).
REQ-005 The block SHALL have port start_stop  input  1  one-cycle pulse that toggles run/pause.
REQ-006 The block SHALL have port lap  input  1  one-cycle pulse that toggles lap hold.
REQ-007 The block SHALL have port clear  input  1  one-cycle pulse that returns the block to IDLE.
REQ-008 The block SHALL have port count_down  input  1  direction level; 1 = countdown from preset.
REQ-009 The block SHALL have port preset_min  input  7  binary preset minutes.
REQ-010 The block SHALL have port preset_sec  input  6  binary preset seconds.
REQ-011 The block SHALL have ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  displayed BCD digits.
REQ-012 The block SHALL have port running  output  1  high in RUN.
REQ-013 The block SHALL have port lap_active  output  1  high while the display is frozen.
REQ-014 The block SHALL have port done  output  1  high in EXPIRED.

Function
REQ-015 The block SHALL hold the live time as four BCD digits, with seconds 00..59 and minutes 00..MIN_LIMIT.
REQ-016 The block SHALL implement states IDLE, RUN, PAUSE and EXPIRED; all outputs are registered.
REQ-017 In IDLE, each cycle the live value SHALL load 00:00 if count_down=0, or the clamped preset if count_down=1.
- Clamping: preset_min is limited to MIN_LIMIT and preset_sec to 59.
REQ-018 In IDLE, start_stop SHALL enter RUN, except when count_down=1 with a loaded value of 00:00; that pulse is ignored.
- The direction is latched on the IDLE->RUN transition and count_down is ignored outside IDLE.
REQ-019 In RUN, an up count on tick SHALL step as follows:
- sec+1, with 59 -> 00 carrying into min+1;
- MIN_LIMIT:59 wraps to 00:00 and the block stays in RUN.
REQ-020 In RUN, a down count on tick SHALL decrement with borrow; the tick that reaches 00:00 also enters EXPIRED.
REQ-021 Timing: a tick in cycle n SHALL appear on the digits in cycle n+1 (one-cycle latency).
REQ-022 start_stop SHALL toggle RUN <-> PAUSE.
- A tick in the same cycle as RUN->PAUSE is counted.
- A tick in the same cycle as PAUSE->RUN is not counted.
- Ticks in PAUSE are ignored.
REQ-023 In EXPIRED, the live value SHALL hold 00:00 with done=1; start_stop, lap and tick are ignored and only clear exits.
REQ-024 clear SHALL force IDLE from any state and clear lap_active; it has priority over every simultaneous input.
REQ-025 lap in RUN or PAUSE SHALL toggle lap_active.
- On the 0->1 edge it snapshots the pre-update live digits into a lap register.
- While lap_active=1, the outputs show the lap register and counting continues.
REQ-026 lap in IDLE or EXPIRED SHALL be ignored; entering IDLE or EXPIRED SHALL clear lap_active.
REQ-027 When lap_active=0, the output digits SHALL equal the live digits.

Reset
REQ-028 When rst_n=0, the block SHALL immediately (asynchronously) force the following, independent of clk:
- state IDLE, live and lap digits 0;
- min_tens, min_ones, sec_tens, sec_ones = 0;
- running, lap_active and done = 0.
REQ-029 The first edge after rst_n rises SHALL perform normal IDLE behaviour, including the preset load.

Configuration
REQ-030 Macro LAP_CAPTURE_EN defined: the lap register and REQ-025..REQ-027 SHALL be implemented.
REQ-031 Macro LAP_CAPTURE_EN undefined: the lap register SHALL be omitted, lap is ignored, lap_active is tied 0, and the outputs always show the live digits.

Verification
REQ-032 Scenario: up mode, start, 61 ticks -> digits 0,1,0,1 and running=1; start_stop then 5 ticks -> digits unchanged, running=0.
REQ-033 Scenario: MIN_LIMIT=2, up mode at 02:59, one tick -> 00:00, still RUN.
REQ-034 Scenario: count_down=1, preset 0 min 2 s, start, 2 ticks -> 00:00, done=1 the cycle after the second tick; a further start_stop leaves done=1; clear -> done=0, digits 0,0,0,2.
REQ-035 Scenario: preset_min=120 with MIN_LIMIT=59 in IDLE -> digits 5,9 for minutes.
REQ-036 Scenario (LAP_CAPTURE_EN): lap at 00:10, then 5 ticks -> display 00:10, lap_active=1; lap again -> display 00:15, lap_active=0.
REQ-037 Scenario: clear and start_stop asserted together in RUN -> IDLE; rst_n pulsed low mid-RUN -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/lap_timer_core.sv
// BCD mm:ss stopwatch / countdown timer with run, pause, expiry and lap hold.
// Define LAP_CAPTURE_EN to build the lap register; otherwise lap is ignored and lap_active is 0.
module lap_timer_core #(
  parameter int MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       count_down,
  input  logic [6:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       lap_active,
  output logic       done
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_EXPIRED = 2'd3} state_t;

  localparam logic [3:0] LIM_T = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_O = 4'(MIN_LIMIT % 10);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_live, w_live_nxt;  // {min_tens, min_ones, sec_tens, sec_ones}
  logic [15:0] r_disp, w_disp_nxt;
  logic [15:0] w_load, w_up, w_dn;
  logic [6:0]  w_min_c;
  logic [5:0]  w_sec_c;
  logic        r_dir, r_running, r_done;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] t;
    logic [6:0] o;
    t = v / 7'd10;
    o = v - (t * 7'd10);
    return {t[3:0], o[3:0]};
  endfunction

  function automatic logic [15:0] step_up(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd9) begin
      so = so + 4'd1;
    end else begin
      so = 4'd0;
      if (st != 4'd5) begin
        st = st + 4'd1;
      end else begin
        st = 4'd0;
        if ((mt == LIM_T) && (mo == LIM_O)) begin
          mt = 4'd0;
          mo = 4'd0;
        end else if (mo != 4'd9) begin
          mo = mo + 4'd1;
        end else begin
          mo = 4'd0;
          mt = mt + 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  function automatic logic [15:0] step_down(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (v == 16'd0) begin
      return 16'd0;
    end else if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign w_min_c = (preset_min > 7'(MIN_LIMIT)) ? 7'(MIN_LIMIT) : preset_min;
  assign w_sec_c = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
  assign w_load  = count_down ? {to_bcd(w_min_c), to_bcd({1'b0, w_sec_c})} : 16'd0;
  assign w_up    = step_up(r_live);
  assign w_dn    = step_down(r_live);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // clear dominates; a countdown reaching 00:00 wins over a simultaneous pause request
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = (start_stop && !(count_down && (w_load == 16'd0))) ? S_RUN : S_IDLE;
        S_RUN: begin
          if (tick && r_dir && (w_dn == 16'd0)) w_state_nxt = S_EXPIRED;
          else if (start_stop)                  w_state_nxt = S_PAUSE;
          else                                  w_state_nxt = S_RUN;
        end
        S_PAUSE:   w_state_nxt = start_stop ? S_RUN : S_PAUSE;
        S_EXPIRED: w_state_nxt = S_EXPIRED;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_live_nxt = r_live;
    if (clear || (r_state == S_IDLE))      w_live_nxt = w_load;
    else if (r_state == S_EXPIRED)         w_live_nxt = 16'd0;
    else if ((r_state == S_RUN) && tick)   w_live_nxt = r_dir ? w_dn : w_up;
    else                                   w_live_nxt = r_live;
  end

`ifdef LAP_CAPTURE_EN
  logic [15:0] r_lap, w_lap_nxt;
  logic        r_lap_act, w_lap_act_nxt, w_lap_ok, w_keep_lap;

  assign w_keep_lap = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
  assign w_lap_ok   = lap && ((r_state == S_RUN) || (r_state == S_PAUSE)) && w_keep_lap;

  // Snapshot uses the pre-update live value so a same-cycle tick is not captured
  always_comb begin
    w_lap_nxt     = r_lap;
    w_lap_act_nxt = r_lap_act;
    if (!w_keep_lap) begin
      w_lap_act_nxt = 1'b0;
    end else if (w_lap_ok) begin
      w_lap_act_nxt = !r_lap_act;
      if (!r_lap_act) w_lap_nxt = r_live;
      else            w_lap_nxt = r_lap;
    end else begin
      w_lap_act_nxt = r_lap_act;
    end
  end

  assign w_disp_nxt = w_lap_act_nxt ? w_lap_nxt : w_live_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap     <= 16'd0;
      r_lap_act <= 1'b0;
    end else begin
      r_lap     <= w_lap_nxt;
      r_lap_act <= w_lap_act_nxt;
    end
  end

  assign lap_active = r_lap_act;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign w_disp_nxt   = w_live_nxt;
  assign lap_active   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 16'd0;
      r_disp    <= 16'd0;
      r_dir     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_live    <= w_live_nxt;
      r_disp    <= w_disp_nxt;
      r_dir     <= (r_state == S_IDLE) ? count_down : r_dir;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_EXPIRED);
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = r_disp;
  assign running = r_running;
  assign done    = r_done;
endmodule

// File: tb/tb_lap_timer_core.sv
// Bench for lap_timer_core: two instances (MIN_LIMIT 59 and 2) against a seconds-count model.
module tb_lap_timer_core;
  logic       clk = 1'b0, rst_n = 1'b1;
  logic       tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0, count_down = 1'b0;
  logic [6:0] preset_min = 7'd0;
  logic [5:0] preset_sec = 6'd0;
  logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic       a_run, a_la, a_done, b_run, b_la, b_done;
  int total = 0, bad = 0;

`ifdef LAP_CAPTURE_EN
  localparam bit LAPEN = 1'b1;
`else
  localparam bit LAPEN = 1'b0;
`endif

  always #5 clk = ~clk;

  lap_timer_core dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
    .count_down(count_down), .preset_min(preset_min), .preset_sec(preset_sec),
    .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
    .running(a_run), .lap_active(a_la), .done(a_done));

  lap_timer_core #(.MIN_LIMIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
    .count_down(count_down), .preset_min(preset_min), .preset_sec(preset_sec),
    .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
    .running(b_run), .lap_active(b_la), .done(b_done));

  // Model: states 0 idle, 1 run, 2 pause, 3 expired; time held as total seconds
  int m_st[2], m_t[2], m_dir[2], m_la[2], m_lapv[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [15:0] dig(input int v);
    int m, s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic mstep(input int k);
    int st, t, dir, la, lapv, lim, ldv, pm, ps;
    st = m_st[k]; t = m_t[k]; dir = m_dir[k]; la = m_la[k]; lapv = m_lapv[k];
    lim = (k == 0) ? 59 : 2;
    pm  = (int'(preset_min) > lim) ? lim : int'(preset_min);
    ps  = (int'(preset_sec) > 59) ? 59 : int'(preset_sec);
    ldv = count_down ? (pm * 60 + ps) : 0;
    if (clear) begin
      st = 0; t = ldv; la = 0;
    end else begin
      case (st)
        0: begin
          t = ldv; dir = int'(count_down);
          if (start_stop && !(count_down && ldv == 0)) st = 1;
        end
        1: begin
          if (LAPEN && lap) begin
            if (la == 0) lapv = t;
            la = (la == 0) ? 1 : 0;
          end
          if (tick) t = (dir != 0) ? t - 1 : (t + 1) % ((lim + 1) * 60);
          if (tick && dir != 0 && t == 0) begin st = 3; la = 0; end
          else if (start_stop) st = 2;
        end
        2: begin
          if (LAPEN && lap) begin
            if (la == 0) lapv = t;
            la = (la == 0) ? 1 : 0;
          end
          if (start_stop) st = 1;
        end
        default: t = 0;
      endcase
    end
    m_st[k] <= st; m_t[k] <= t; m_dir[k] <= dir; m_la[k] <= la; m_lapv[k] <= lapv;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] <= 0; m_t[k] <= 0; m_dir[k] <= 0; m_la[k] <= 0; m_lapv[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) mstep(k);
    end
  end

  task automatic check_dut(input int k, input logic [15:0] dg, input logic r, input logic la, input logic dn);
    int v;
    v = (m_la[k] != 0) ? m_lapv[k] : m_t[k];
    chk($sformatf("dut%0d digits", k), {16'd0, dg}, {16'd0, dig(v)});
    chk($sformatf("dut%0d running", k), {31'd0, r}, {31'd0, m_st[k] == 1});
    chk($sformatf("dut%0d lap_active", k), {31'd0, la}, {31'd0, m_la[k] != 0});
    chk($sformatf("dut%0d done", k), {31'd0, dn}, {31'd0, m_st[k] == 3});
  endtask

  // Compare process: every falling edge, both instances against the model
  always @(negedge clk) begin
    check_dut(0, {a_mt, a_mo, a_st, a_so}, a_run, a_la, a_done);
    check_dut(1, {b_mt, b_mo, b_st, b_so}, b_run, b_la, b_done);
  end

  task automatic cyc(input logic t, input logic ss, input logic lp, input logic cl);
    tick = t; start_stop = ss; lap = lp; clear = cl;
    @(posedge clk);
    #1;
    tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] da();
    return {16'd0, a_mt, a_mo, a_st, a_so};
  endfunction

  function automatic logic [31:0] db();
    return {16'd0, b_mt, b_mo, b_st, b_so};
  endfunction

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset digits", da(), 32'h0);
    chk("reset flags", {29'd0, a_run, a_la, a_done}, 32'd0);
    chk("reset digits lim2", db(), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(61);
    chk("up61 digits", da(), 32'h0101);
    chk("up61 running", {31'd0, a_run}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    chk("paused digits", da(), 32'h0101);
    chk("paused running", {31'd0, a_run}, 32'd0);

    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(179);
    chk("lim2 pre-wrap", db(), 32'h0259);
    ticks(1);
    chk("lim2 wrap", db(), 32'h0000);
    chk("lim2 still run", {31'd0, b_run}, 32'd1);
    chk("lim59 3 min", da(), 32'h0300);

    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("clear+start running", {31'd0, a_run}, 32'd0);
    chk("clear+start digits", da(), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart from idle", {31'd0, a_run}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    count_down = 1'b1; preset_min = 7'd0; preset_sec = 6'd2;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("preset 2s", da(), 32'h0002);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("down 1s", da(), 32'h0001);
    chk("down not done", {31'd0, a_done}, 32'd0);
    ticks(1);
    chk("down 0s", da(), 32'h0000);
    chk("expired done", {31'd0, a_done}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("done holds", {31'd0, a_done}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear done", {31'd0, a_done}, 32'd0);
    chk("clear reload", da(), 32'h0002);
    preset_sec = 6'd0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero start ignored", {31'd0, a_run}, 32'd0);

    preset_min = 7'd120; preset_sec = 6'd63;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("clamp lim59", da(), 32'h5959);
    chk("clamp lim2", db(), 32'h0259);

    count_down = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(5);
    if (LAPEN) begin
      chk("lap hold digits", da(), 32'h0010);
      chk("lap hold active", {31'd0, a_la}, 32'd1);
    end else begin
      chk("no-lap digits", da(), 32'h0015);
      chk("no-lap active", {31'd0, a_la}, 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lap release digits", da(), 32'h0015);
    chk("lap release active", {31'd0, a_la}, 32'd0);

    ticks(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst digits", da(), 32'h0);
    chk("async rst flags", {29'd0, a_run, a_la, a_done}, 32'd0);
    chk("async rst lim2", db(), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_down = 1'b1; preset_min = 7'd3; preset_sec = 6'd7;
    @(posedge clk); #1;
    chk("post-reset load", da(), 32'h0307);
    chk("post-reset load lim2", db(), 32'h0207);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        count_down = 1'($urandom_range(0, 1));
        preset_min = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 1));
        preset_sec = 6'($urandom_range(0, 63));
      end
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 79) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
